// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard stall/flush controller.
package hazard_stall_ctrl_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // A requested bubble count of zero still costs one bubble.
    function automatic logic [1:0] eff_cycles(input logic [1:0] cyc);
        return (cyc == 2'd0) ? 2'd1 : cyc;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Front-end hazard request/control bundle between the detector side and the pipeline regs.
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;

    logic             fetch_nop_LD;
    logic [1:0]       stall_cycles;
    logic             branch_taken;
    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             stall_active;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output fetch_nop_LD, stall_cycles, branch_taken,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
               stall_active, stall_count, flush_count
    );

    modport slave (
        input  fetch_nop_LD, stall_cycles, branch_taken,
        output pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
               stall_active, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Width-parameterised saturating event counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Front-end hold/flush sequencer: load-use bubbles, taken-branch flushes, event counters.
//   state    | meaning
//   ST_RUN   | normal fetch; a load-use request bubbles this same cycle
//   ST_STALL | multi-cycle bubble in progress, r_rem bubbles still owed
//   ST_FLUSH | cycle after a taken branch; discard the in-flight fetch
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_nop_LD,
    input  logic [1:0]       stall_cycles,
    input  logic             branch_taken,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    state_t     r_state;
    logic [1:0] r_rem;
    logic [1:0] w_eff;
    logic       w_pc_we;
    logic       w_ifid_we;
    logic       w_ifid_flush;
    logic       w_idex_bubble;
    logic       w_stall_active;
    logic       w_flush_inc;

    assign w_eff = eff_cycles(stall_cycles);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_rem   <= 2'd0;
        end else if (branch_taken) begin
            r_state <= ST_FLUSH;
            r_rem   <= 2'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (fetch_nop_LD && (w_eff > 2'd1)) begin
                        r_state <= ST_STALL;
                        r_rem   <= w_eff - 2'd1;
                    end
                end
                ST_STALL: begin
                    r_rem <= r_rem - 2'd1;
                    if (r_rem == 2'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_rem   <= 2'd0;
                end
            endcase
        end
    end

    // Enables must react in the request cycle itself, so they decode state plus inputs.
    always_comb begin
        w_pc_we        = 1'b1;
        w_ifid_we      = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_stall_active = 1'b0;
        if (rst) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (branch_taken) begin
            w_ifid_we     = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (fetch_nop_LD) begin
                        w_pc_we        = 1'b0;
                        w_ifid_we      = 1'b0;
                        w_idex_bubble  = 1'b1;
                        w_stall_active = 1'b1;
                    end
                end
                ST_STALL: begin
                    w_pc_we        = 1'b0;
                    w_ifid_we      = 1'b0;
                    w_idex_bubble  = 1'b1;
                    w_stall_active = 1'b1;
                end
                ST_FLUSH: begin
                    w_ifid_we    = 1'b0;
                    w_ifid_flush = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_flush_inc   = branch_taken && !rst;
    assign pc_write_en   = w_pc_we;
    assign ifid_write_en = w_ifid_we;
    assign ifid_flush    = w_ifid_flush;
    assign idex_bubble   = w_idex_bubble;
    assign stall_active  = w_stall_active;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_active),
        .o_cnt (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_flush_inc),
        .o_cnt (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl with a queue-based scoreboard.
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    // Output flag order: {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, stall_active}
    localparam logic [4:0] RUNV = 5'b11000;
    localparam logic [4:0] STV  = 5'b00011;
    localparam logic [4:0] BRV  = 5'b10110;
    localparam logic [4:0] FLV  = 5'b10100;
    localparam logic [4:0] RSTV = 5'b00110;

    typedef struct packed {
        logic [4:0]  flags;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   exp_s;
    int   exp_f;
    exp_t q[$];

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_nop_LD  (bus.fetch_nop_LD),
        .stall_cycles  (bus.stall_cycles),
        .branch_taken  (bus.branch_taken),
        .pc_write_en   (bus.pc_write_en),
        .ifid_write_en (bus.ifid_write_en),
        .ifid_flush    (bus.ifid_flush),
        .idex_bubble   (bus.idex_bubble),
        .stall_active  (bus.stall_active),
        .stall_count   (bus.stall_count),
        .flush_count   (bus.flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the hand-computed response for it.
    task automatic cyc(input logic r, input logic ld, input logic [1:0] sc,
                       input logic br, input logic [4:0] flags);
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        bus.fetch_nop_LD = ld;
        bus.stall_cycles = sc;
        bus.branch_taken = br;
        e.flags = flags;
        e.scnt  = exp_s[15:0];
        e.fcnt  = exp_f[15:0];
        q.push_back(e);
        if (r) begin
            exp_s = 0;
            exp_f = 0;
        end else begin
            if (flags[0] && exp_s < 65535) exp_s = exp_s + 1;
            if (br && exp_f < 65535) exp_f = exp_f + 1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks = checks + 1;
                if ({bus.pc_write_en, bus.ifid_write_en, bus.ifid_flush,
                     bus.idex_bubble, bus.stall_active} !== e.flags) begin
                    failures = failures + 1;
                    $display("FAIL flags t=%0t got=%b want=%b", $time,
                             {bus.pc_write_en, bus.ifid_write_en, bus.ifid_flush,
                              bus.idex_bubble, bus.stall_active}, e.flags);
                end
                checks = checks + 1;
                if (bus.stall_count !== e.scnt) begin
                    failures = failures + 1;
                    $display("FAIL stall_count t=%0t got=%0d want=%0d", $time,
                             bus.stall_count, e.scnt);
                end
                checks = checks + 1;
                if (bus.flush_count !== e.fcnt) begin
                    failures = failures + 1;
                    $display("FAIL flush_count t=%0t got=%0d want=%0d", $time,
                             bus.flush_count, e.fcnt);
                end
            end
        end
    end

    initial begin : stimulus
        checks           = 0;
        failures         = 0;
        exp_s            = 0;
        exp_f            = 0;
        rst              = 1'b1;
        bus.fetch_nop_LD = 1'b0;
        bus.stall_cycles = 2'd0;
        bus.branch_taken = 1'b0;

        repeat (3) cyc(1, 0, 2'd0, 0, RSTV);
        repeat (2) cyc(0, 0, 2'd0, 0, RUNV);

        // single-cycle stall, and stall_cycles=0 treated as 1
        cyc(0, 1, 2'd1, 0, STV);
        cyc(0, 0, 2'd0, 0, RUNV);
        cyc(0, 1, 2'd0, 0, STV);
        cyc(0, 0, 2'd0, 0, RUNV);

        // three-cycle stall; request held high must not extend it
        cyc(0, 1, 2'd3, 0, STV);
        cyc(0, 1, 2'd3, 0, STV);
        cyc(0, 1, 2'd0, 0, STV);
        cyc(0, 0, 2'd0, 0, RUNV);

        cyc(0, 1, 2'd2, 0, STV);
        cyc(0, 0, 2'd0, 0, STV);
        cyc(0, 0, 2'd0, 0, RUNV);

        // branch aborts a stall on its second cycle
        cyc(0, 1, 2'd3, 0, STV);
        cyc(0, 0, 2'd0, 1, BRV);
        cyc(0, 0, 2'd0, 0, FLV);
        cyc(0, 0, 2'd0, 0, RUNV);

        // load-use ignored in FLUSH
        cyc(0, 0, 2'd0, 1, BRV);
        cyc(0, 1, 2'd3, 0, FLV);
        cyc(0, 0, 2'd0, 0, RUNV);

        // back-to-back branches
        cyc(0, 0, 2'd0, 1, BRV);
        cyc(0, 0, 2'd0, 1, BRV);
        cyc(0, 0, 2'd0, 0, FLV);
        cyc(0, 0, 2'd0, 0, RUNV);

        // simultaneous stall request and branch
        cyc(0, 1, 2'd3, 1, BRV);
        cyc(0, 0, 2'd0, 0, FLV);
        cyc(0, 0, 2'd0, 0, RUNV);

        // reset mid-STALL and mid-FLUSH
        cyc(0, 1, 2'd3, 0, STV);
        cyc(1, 0, 2'd0, 0, RSTV);
        cyc(0, 0, 2'd0, 0, RUNV);
        cyc(0, 1, 2'd2, 0, STV);
        cyc(1, 1, 2'd2, 0, RSTV);
        cyc(0, 0, 2'd0, 0, RUNV);
        cyc(0, 0, 2'd0, 1, BRV);
        cyc(1, 0, 2'd0, 0, RSTV);
        cyc(0, 0, 2'd0, 0, RUNV);

        // saturation of stall_count
        repeat (65540) cyc(0, 1, 2'd1, 0, STV);
        repeat (3) cyc(0, 0, 2'd0, 0, RUNV);
        cyc(0, 1, 2'd1, 0, STV);
        cyc(0, 0, 2'd0, 0, RUNV);

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain remaining=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
